// File: rtl/strb_gen_pkg.sv
// Shared definitions for the multi-channel strobe generator (strb_gen_mc).
package strb_gen_pkg;

  localparam int unsigned STRB_BW_DEF     = 8;
  localparam int unsigned STRB_NCH_DEF    = 4;
  localparam int unsigned STRB_PRE_BW_DEF = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } os_state_e;

endpackage

// File: rtl/strb_channel.sv
// One strobe channel: tick-driven counter with continuous or one-shot operation.
module strb_channel
  import strb_gen_pkg::*;
#(
  parameter int unsigned BW = STRB_BW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          tick_i,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          oneshot_i,
  input  logic          trig_i,
  input  logic [BW-1:0] period_i,
  output logic          strb_o,
  output logic          busy_o
);

  os_state_e     state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          strb_q, strb_d;
  logic          busy_q, busy_d;
  logic          wrap;

  assign wrap = (cnt_q >= period_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    strb_d  = 1'b0;
    busy_d  = busy_q;
    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else if (clr_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = !oneshot_i;
    end else if (!oneshot_i) begin
      // Continuous mode parks the FSM in IDLE; the count itself carries over.
      state_d = ST_IDLE;
      busy_d  = 1'b1;
      if (tick_i) begin
        if (wrap) begin
          cnt_d  = '0;
          strb_d = |period_i;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
          if (trig_i) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            busy_d  = 1'b1;
          end
        end
        ST_RUN: begin
          busy_d = 1'b1;
          if (tick_i) begin
            if (wrap) begin
              cnt_d   = '0;
              strb_d  = |period_i;
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + BW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      strb_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      strb_q  <= strb_d;
      busy_q  <= busy_d;
    end
  end

  assign strb_o = strb_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/strb_gen_mc.sv
// Multi-channel strobe generator: shared prescaler tick feeding NCH channels.
// Define STRB_GEN_SYNC_EN to add sync_i, a synchronous phase-alignment clear.
module strb_gen_mc
  import strb_gen_pkg::*;
#(
  parameter int unsigned BW     = STRB_BW_DEF,
  parameter int unsigned NCH    = STRB_NCH_DEF,
  parameter int unsigned PRE_BW = STRB_PRE_BW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef STRB_GEN_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic [PRE_BW-1:0] prescale_i,
  input  logic [NCH-1:0]    en_i,
  input  logic [NCH-1:0]    oneshot_i,
  input  logic [NCH-1:0]    trig_i,
  input  logic [NCH*BW-1:0] period_i,
  output logic [NCH-1:0]    strb_o,
  output logic [NCH-1:0]    busy_o
);

  logic              clr;
  logic              tick;
  logic [PRE_BW-1:0] pre_q, pre_d;

`ifdef STRB_GEN_SYNC_EN
  assign clr = sync_i;
`else
  assign clr = 1'b0;
`endif

  // >= rather than == so a prescale lowered below the count wraps at once.
  always_comb begin
    tick  = (pre_q >= prescale_i);
    pre_d = (clr || tick) ? '0 : pre_q + PRE_BW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    strb_channel #(
      .BW(BW)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .tick_i    (tick),
      .clr_i     (clr),
      .en_i      (en_i[k]),
      .oneshot_i (oneshot_i[k]),
      .trig_i    (trig_i[k]),
      .period_i  (period_i[k*BW +: BW]),
      .strb_o    (strb_o[k]),
      .busy_o    (busy_o[k])
    );
  end

endmodule

// File: tb/tb_strb_gen_mc.sv
// Self-checking bench for strb_gen_mc: directed scenarios plus random stimulus
// against a behavioural model; covers sync_i when STRB_GEN_SYNC_EN is defined.
module tb_strb_gen_mc;

  localparam int BW = 8, NCH = 4, PRE_BW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sync = 1'b0;
  logic [PRE_BW-1:0] prescale = '0;
  logic [NCH-1:0]    en = '0, oneshot = '0, trig = '0;
  logic [NCH*BW-1:0] period = '0;
  logic [NCH-1:0]    strb_o, busy_o;

  always #5 clk = ~clk;

  strb_gen_mc #(.BW(BW), .NCH(NCH), .PRE_BW(PRE_BW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
`ifdef STRB_GEN_SYNC_EN
    .sync_i     (sync),
`endif
    .prescale_i (prescale),
    .en_i       (en),
    .oneshot_i  (oneshot),
    .trig_i     (trig),
    .period_i   (period),
    .strb_o     (strb_o),
    .busy_o     (busy_o)
  );

  // Behavioural model: ticks elapsed per channel, run flags, expected outputs.
  int       m_pre;
  int       m_cnt [NCH];
  bit       m_run [NCH];
  logic [NCH-1:0] exp_strb = '0, exp_busy = '0;
  int       checks = 0, fails = 0, cyc = 0;

  task automatic model_step();
    bit tk;
    int p;
    if (rst) begin
      m_pre = 0;
      for (int k = 0; k < NCH; k++) begin m_cnt[k] = 0; m_run[k] = 0; end
      exp_strb = '0; exp_busy = '0;
      return;
    end
    tk = (m_pre >= int'(prescale));
    m_pre = (sync || tk) ? 0 : m_pre + 1;
    for (int k = 0; k < NCH; k++) begin
      p = int'(period[k*BW +: BW]);
      exp_strb[k] = 1'b0;
      if (!en[k]) begin
        m_cnt[k] = 0; m_run[k] = 0; exp_busy[k] = 1'b0;
      end else if (sync) begin
        m_cnt[k] = 0; m_run[k] = 0; exp_busy[k] = !oneshot[k];
      end else if (!oneshot[k]) begin
        m_run[k] = 0; exp_busy[k] = 1'b1;
        if (tk) begin
          if (m_cnt[k] >= p) begin m_cnt[k] = 0; exp_strb[k] = (p != 0); end
          else m_cnt[k]++;
        end
      end else if (!m_run[k]) begin
        exp_busy[k] = trig[k];
        if (trig[k]) begin m_run[k] = 1; m_cnt[k] = 0; end
      end else begin
        exp_busy[k] = 1'b1;
        if (tk) begin
          if (m_cnt[k] >= p) begin
            m_cnt[k] = 0; exp_strb[k] = (p != 0); m_run[k] = 0; exp_busy[k] = 1'b0;
          end else m_cnt[k]++;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
    end
  endtask

  // Inputs change only at negedges; outputs are compared at the following negedge.
  task automatic tick_cycle();
    model_step();
    @(negedge clk);
    cyc++;
    check("strb_o", int'(strb_o), int'(exp_strb));
    check("busy_o", int'(busy_o), int'(exp_busy));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; trig = '0; oneshot = '0; sync = 1'b0;
    tick_cycle();
    check("reset_strb", int'(strb_o), 0);
    check("reset_busy", int'(busy_o), 0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic set_per(input int k, input int v);
    period[k*BW +: BW] = BW'(v);
  endtask

  initial begin
    int f, s, n, bc, t, m;

    // Continuous, prescale 0: ch0 P=3 strobes every 4 clocks, ch2 P=0 never.
    do_reset();
    prescale = '0; en = 4'b0101; set_per(0, 3); set_per(2, 0);
    f = -1; s = -1; n = 0;
    for (int i = 0; i < 12; i++) begin
      tick_cycle();
      if (cyc == 1) check("busy0_first", int'(busy_o[0]), 1);
      if (strb_o[0]) begin if (f < 0) f = cyc; else if (s < 0) s = cyc; end
      n += int'(strb_o[2]);
    end
    check("ch0_first_strb", f, 4);
    check("ch0_second_strb", s, 8);
    check("ch2_p0_strobes", n, 0);

    // Prescale 2: ch1 P=1 strobes every 6 clocks.
    do_reset();
    prescale = 4'd2; en = 4'b0010; set_per(1, 1);
    f = -1; s = -1;
    for (int i = 0; i < 14; i++) begin
      tick_cycle();
      if (strb_o[1]) begin if (f < 0) f = cyc; else if (s < 0) s = cyc; end
    end
    check("ch1_first_strb", f, 6);
    check("ch1_second_strb", s, 12);

    // One-shot ch3 P=4; second trigger while running is ignored.
    do_reset();
    prescale = '0; en = 4'b1000; oneshot = 4'b1000; set_per(3, 4);
    tick_cycle(); tick_cycle();
    trig[3] = 1'b1; tick_cycle(); trig[3] = 1'b0;
    t = cyc; bc = int'(busy_o[3]); n = int'(strb_o[3]); s = -1;
    for (int i = 0; i < 9; i++) begin
      trig[3] = (i == 1);
      tick_cycle();
      bc += int'(busy_o[3]);
      if (strb_o[3]) begin n++; s = cyc; end
    end
    trig[3] = 1'b0;
    check("os_busy_cycles", bc, 5);
    check("os_strobes", n, 1);
    check("os_strb_cycle", s - t, 5);

    // Mid-run period reduction: 10 -> 5 once cnt has reached 7.
    do_reset();
    prescale = '0; en = 4'b0001; set_per(0, 10);
    repeat (7) tick_cycle();
    set_per(0, 5);
    f = -1; s = -1;
    for (int i = 0; i < 10; i++) begin
      tick_cycle();
      if (strb_o[0]) begin if (f < 0) f = cyc; else if (s < 0) s = cyc; end
    end
    check("chg_first_strb", f, 8);
    check("chg_second_strb", s, 14);

    // en dropped together with trig: no RUN entry.
    do_reset();
    en = 4'b0001; oneshot = 4'b0001; set_per(0, 3);
    tick_cycle(); tick_cycle();
    en[0] = 1'b0; trig[0] = 1'b1; tick_cycle();
    check("en_drop_busy", int'(busy_o[0]), 0);
    en[0] = 1'b1; trig[0] = 1'b0; n = 0;
    for (int i = 0; i < 6; i++) begin
      tick_cycle();
      n += int'(strb_o[0]) + int'(busy_o[0]);
    end
    check("en_drop_activity", n, 0);

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) prescale = PRE_BW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) en = NCH'($urandom);
      if ($urandom_range(0, 31) == 0) oneshot = NCH'($urandom);
      if ($urandom_range(0, 11) == 0)
        set_per($urandom_range(0, NCH - 1),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 7));
      trig = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
`ifdef STRB_GEN_SYNC_EN
      sync = ($urandom_range(0, 49) == 0);
`endif
      tick_cycle();
    end
    trig = '0; sync = 1'b0;

    // Asynchronous reset while running clears outputs without a clock edge.
    en = 4'hF; oneshot = '0; prescale = '0;
    for (int k = 0; k < NCH; k++) set_per(k, 2);
    repeat (3) tick_cycle();
    check("pre_rst_busy", int'(busy_o), 15);
    #2 rst = 1'b1;
    #1;
    check("async_rst_strb", int'(strb_o), 0);
    check("async_rst_busy", int'(busy_o), 0);
    tick_cycle();
    rst = 1'b0;

`ifdef STRB_GEN_SYNC_EN
    // Channels at different phases realign after a sync pulse.
    do_reset();
    prescale = 4'd1; en = 4'b0001; set_per(0, 5); set_per(1, 5);
    repeat (3) tick_cycle();
    en = 4'b0011;
    repeat (4) tick_cycle();
    sync = 1'b1; tick_cycle(); sync = 1'b0;
    n = 0; m = 0;
    for (int i = 0; i < 30; i++) begin
      tick_cycle();
      n += int'(strb_o[0]);
      if (strb_o[0] != strb_o[1]) m++;
    end
    check("sync_ch0_strobes", n, 2);
    check("sync_phase_diff", m, 0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/strb_gen_mc.md
Name: strb_gen_mc

Overview:
- Multi-channel programmable strobe generator, successor to the single-channel strobe block in the tone macro.
- One shared prescaler produces a tick; NCH independent channel counters divide that tick.
- Each channel has its own period, enable, and continuous/one-shot mode.
- Feeds tone, envelope and sequencer timing in the same design.

Parameters:
- BW, 8, channel period/counter width
- NCH, 4, number of channels
- PRE_BW, 4, prescaler width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; rst_i asynchronous, active-high; clock clk_i
- prescale_i  in  PRE_BW  tick every prescale_i+1 clocks
- en_i  in  NCH  per-channel enable
- oneshot_i  in  NCH  per-channel mode: 1 = one-shot, 0 = continuous
- trig_i  in  NCH  per-channel one-shot start pulse
- period_i  in  NCH*BW  per-channel period; channel k uses bits [k*BW +: BW]
- strb_o  out  NCH  per-channel strobe, registered, one clk wide
- busy_o  out  NCH  per-channel counting indicator, registered

Behaviour:
- Reset: prescaler count 0, all channel counters 0, all one-shot states IDLE, strb_o=0, busy_o=0.
- Prescaler:
  - Free-running, counts 0..prescale_i.
  - tick=1 in the cycle where count >= prescale_i; count then wraps to 0, else increments.
  - prescale_i=0 gives tick every clock.
  - A prescale_i reduced below the current count wraps on the next clock.
- Channel counter update, on a tick, when the channel is counting:
  - If cnt >= period: cnt<=0, strb<=(period!=0).
  - Else: cnt<=cnt+1, strb<=0.
  - Non-tick cycles: strb<=0, cnt holds.
- Continuous mode (oneshot_i=0):
  - Counting whenever en_i=1.
  - Period P>=1 gives one strobe every P+1 ticks. With prescale 0, that is every P+1 clocks.
  - The first strobe after enable arrives P+1 ticks after the enable cycle.
  - busy_o = registered en_i.
- One-shot mode (oneshot_i=1), per-channel FSM:
  - IDLE: cnt=0, busy_o=0. trig_i=1 with en_i=1 moves to RUN and clears cnt. Ticks in the trig cycle are not counted.
  - RUN: counts ticks. The strobe fires on the (P+1)th tick. That same cycle returns to IDLE with busy_o<=0.
  - trig_i while RUN is ignored.
- en_i=0: cnt<=0, state<=IDLE, strb<=0, busy<=0 on the next clock. This overrides trig_i in the same cycle.
- Period 0: counter stays 0 and no strobe is ever produced. In one-shot mode, a RUN with period 0 returns to IDLE on the first tick with no strobe.
- Period changed mid-count:
  - New value <= cnt: wrap on the next tick.
  - Larger value: extends the current cycle.
- oneshot_i changed mid-operation: state forced to IDLE, cnt kept. Continuous counting resumes from cnt.
- Widths: counter compare and increment are BW bits unsigned. The increment never overflows because of the >= wrap.

Optional Feature:
- Macro STRB_GEN_SYNC_EN.
- Defined:
  - Adds input sync_i (1 bit).
  - sync_i=1 synchronously clears the prescaler count and all channel counters to 0, forces strb_o=0, and forces one-shot channels to IDLE, in one clock.
  - Used for phase-aligning channels.
  - sync_i has priority over trig_i and ticks; en_i=0 behaviour is unchanged.
- Not defined: no sync_i port; behaviour exactly as above.

Decomposition:
- Package strb_gen_pkg:
  - One-shot state encoding (ST_IDLE=1'b0, ST_RUN=1'b1).
  - Default parameter constants (STRB_BW_DEF=8, STRB_NCH_DEF=4, STRB_PRE_BW_DEF=4).
- Sub-module strb_channel: one channel (counter, FSM, strb/busy registers), instanced NCH times via generate.
- Top level holds the prescaler and the period slicing.

Test Plan:
- Continuous, prescale=0, ch0 period=3, en from reset release -> strb_o[0] pulses every 4 clocks, 1 clk wide; busy_o[0]=1.
- Prescale=2, ch1 period=1 continuous -> strb_o[1] every 6 clocks; ch2 period=0 -> strb_o[2] never asserts.
- One-shot ch3 period=4, prescale=0, trig at cycle T:
  - Single strobe at T+5; busy_o[3] high T+1..T+5.
  - Second trig at T+2 ignored.
- Mid-run change: ch0 continuous period=10, cnt reaches 7, period set to 5 -> strobe at the next tick, cnt 0, then strobes every 6 ticks.
- en_i[0] dropped with trig_i[0] high in the same cycle -> no RUN entry, cnt 0, strb 0. Async rst_i mid-run -> all outputs 0 immediately.
- STRB_GEN_SYNC_EN: channels running at different phases, sync_i pulse -> all counters 0. ch0 and ch1 with equal periods thereafter strobe in the same clock.
